merge_writebuffer: RTL and testbench

Parametrised, write-combining store buffer between the cache and main memory in the MIPS memory subsystem. Holds up to DEPTH pending word writes and drains them in order, one per accepted memory handshake. Merges byte-enabled writes to an address that is already queued and not yet in flight. Provides a combinational snoop port so a read can see buffered bytes, and a flush control for ordering before uncached accesses.

---
 rtl/merge_writebuffer.sv | 161 ++++++++++++++++
 tb/tb_merge_writebuffer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_writebuffer.sv
// merge_writebuffer
// ------------------------------------------------------------------------------
// Write-combining store buffer between the cache and main memory.
//   * Up to DEPTH pending word writes, drained in order to memory, one per
//     accepted handshake (memen & memdone).
//   * A byte-enabled write whose address matches a queued entry that is not the
//     head (the head is always in flight) is merged into that entry (MERGE=1).
//   * Combinational snoop port returns the youngest buffered value per byte.
//   * flush blocks new writes while the buffer drains.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   adr/data/byteen/en   write request from the cache side
//   done         write accepted this cycle (combinational)
//   memadr/memdata/membyteen/memen   head entry towards memory
//   memdone      memory accepted the head entry
//   snoopadr     lookup address; snoophit/snoopdata/snoopbyteen results
//   flush        hold off new writes until empty
//   empty/count  occupancy
// ------------------------------------------------------------------------------
module merge_writebuffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32,
  parameter int MERGE = 1,
  localparam int BW   = DW / 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] data,
  input  logic [BW-1:0] byteen,
  input  logic          en,
  output logic          done,
  output logic [AW-1:0] memadr,
  output logic [DW-1:0] memdata,
  output logic [BW-1:0] membyteen,
  output logic          memen,
  input  logic          memdone,
  input  logic [AW-1:0] snoopadr,
  output logic          snoophit,
  output logic [DW-1:0] snoopdata,
  output logic [BW-1:0] snoopbyteen,
  input  logic          flush,
  output logic          empty,
  output logic [CW-1:0] count
);

  // Control state (reset) and payload storage (no reset: always qualified by valid).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    adr_q  [DEPTH];
  logic [AW-1:0]    adr_d  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [BW-1:0]    be_q   [DEPTH];
  logic [BW-1:0]    be_d   [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             busy;
  logic [DEPTH-1:0] tgt_vec;
  logic             tgt_hit;
  logic [PW-1:0]    tgt_idx;
  logic             wr_nz, push, pop, merge_wr;
  logic [PW-1:0]    snp_idx;

  assign busy = (count_q != '0);

  // Merge candidates: valid, address match, and not the head (head is in flight).
  // The merge rule guarantees at most one entry per address outside the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tgt
    assign tgt_vec[gi] = (MERGE != 0) && valid_q[gi] && (head_q != PW'(gi)) &&
                         (adr_q[gi] == adr);
  end

  always_comb begin
    tgt_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tgt_vec[i]) tgt_idx = PW'(i);
    end
  end

  assign tgt_hit  = |tgt_vec;
  assign wr_nz    = |byteen;
  // done is independent of memdone: a full buffer refuses even if a pop happens now.
  assign done     = en & reset & ~flush & (~wr_nz | tgt_hit | (count_q < CW'(DEPTH)));
  assign push     = done & wr_nz & ~tgt_hit;
  assign merge_wr = done & wr_nz & tgt_hit;
  assign pop      = busy & memdone;

  always_comb begin
    valid_d = valid_q;
    adr_d   = adr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      adr_d[tail_q]   = adr;
      data_d[tail_q]  = data;
      be_d[tail_q]    = byteen;
    end
    if (merge_wr) begin
      for (int b = 0; b < BW; b++) begin
        if (byteen[b]) data_d[tgt_idx][8*b +: 8] = data[8*b +: 8];
      end
      be_d[tgt_idx] = be_q[tgt_idx] | byteen;
    end
    if (pop) valid_d[head_q] = 1'b0;
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    adr_q  <= adr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  // Walk entries oldest to youngest so later matches overwrite earlier bytes.
  always_comb begin
    snoopdata   = '0;
    snoopbyteen = '0;
    snp_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snp_idx = head_q + PW'(i);
      if (valid_q[snp_idx] && (adr_q[snp_idx] == snoopadr)) begin
        for (int b = 0; b < BW; b++) begin
          if (be_q[snp_idx][b]) snoopdata[8*b +: 8] = data_q[snp_idx][8*b +: 8];
        end
        snoopbyteen = snoopbyteen | be_q[snp_idx];
      end
    end
  end

  assign snoophit  = |snoopbyteen;
  assign memen     = busy;
  assign memadr    = busy ? adr_q[head_q]  : '0;
  assign memdata   = busy ? data_q[head_q] : '0;
  assign membyteen = busy ? be_q[head_q]   : '0;
  assign empty     = ~busy;
  assign count     = count_q;

endmodule

// File: tb/tb_merge_writebuffer.sv
// Bench for merge_writebuffer: a directed vector table, a hand-written
// plain-FIFO sequence, and a random run checked against a queue-based model.
// Two instances share inputs: u_m (MERGE=1) and u_f (MERGE=0).
module tb_merge_writebuffer;
  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int CW    = 3;

  logic          clk, reset, en, flush, memdone;
  logic [AW-1:0] adr, snoopadr;
  logic [DW-1:0] data;
  logic [BW-1:0] byteen;

  logic          m_done, m_memen, m_hit, m_empty;
  logic [AW-1:0] m_madr;
  logic [DW-1:0] m_mdata, m_sdata;
  logic [BW-1:0] m_mbe, m_sbe;
  logic [CW-1:0] m_count;
  logic          f_done, f_memen, f_hit, f_empty;
  logic [AW-1:0] f_madr;
  logic [DW-1:0] f_mdata, f_sdata;
  logic [BW-1:0] f_mbe, f_sbe;
  logic [CW-1:0] f_count;

  merge_writebuffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .MERGE(1)) u_m (
    .clk(clk), .reset(reset), .adr(adr), .data(data), .byteen(byteen), .en(en),
    .done(m_done), .memadr(m_madr), .memdata(m_mdata), .membyteen(m_mbe),
    .memen(m_memen), .memdone(memdone), .snoopadr(snoopadr), .snoophit(m_hit),
    .snoopdata(m_sdata), .snoopbyteen(m_sbe), .flush(flush), .empty(m_empty),
    .count(m_count));

  merge_writebuffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .MERGE(0)) u_f (
    .clk(clk), .reset(reset), .adr(adr), .data(data), .byteen(byteen), .en(en),
    .done(f_done), .memadr(f_madr), .memdata(f_mdata), .membyteen(f_mbe),
    .memen(f_memen), .memdone(memdone), .snoopadr(snoopadr), .snoophit(f_hit),
    .snoopdata(f_sdata), .snoopbyteen(f_sbe), .flush(flush), .empty(f_empty),
    .count(f_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, en, fl, md;
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [AW-1:0] sadr;
    logic done;
    int   cnt;
    logic memen;
    logic [AW-1:0] madr;
    logic [DW-1:0] mdata;
    logic [BW-1:0] mbe;
    logic hit;
    logic [DW-1:0] sdata;
    logic [BW-1:0] sbe;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic fl, input logic md,
                     input int a, input logic [DW-1:0] d, input logic [BW-1:0] b, input int sa,
                     input logic x_done, input int x_cnt, input logic x_men, input int x_madr,
                     input logic [DW-1:0] x_md, input logic [BW-1:0] x_mbe, input logic x_hit,
                     input logic [DW-1:0] x_sd, input logic [BW-1:0] x_sb);
    vec_t v;
    v.rst = r; v.en = e; v.fl = fl; v.md = md;
    v.adr = AW'(a); v.data = d; v.be = b; v.sadr = AW'(sa);
    v.done = x_done; v.cnt = x_cnt; v.memen = x_men; v.madr = AW'(x_madr);
    v.mdata = x_md; v.mbe = x_mbe; v.hit = x_hit; v.sdata = x_sd; v.sbe = x_sb;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic fl, input logic md,
                       input int a, input logic [DW-1:0] d, input logic [BW-1:0] b, input int sa);
    reset = r; en = e; flush = fl; memdone = md;
    adr = AW'(a); data = d; byteen = b; snoopadr = AW'(sa);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [AW-1:0] adr; logic [DW-1:0] data; logic [BW-1:0] be; } ent_t;
  ent_t qm[$];
  ent_t qf[$];

  task automatic model_eval(input ent_t q[$], input bit mrg, output logic e_done, output int tgt,
                            output logic [DW-1:0] e_sdata, output logic [BW-1:0] e_sbe);
    tgt = -1;
    if (mrg) begin
      for (int i = 1; i < q.size(); i++) if (q[i].adr == adr) tgt = i;
    end
    e_done = reset && en && !flush && (byteen == '0 || tgt >= 0 || q.size() < DEPTH);
    e_sdata = '0;
    e_sbe   = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].adr == snoopadr) begin
        for (int b = 0; b < BW; b++) if (q[i].be[b]) e_sdata[8*b +: 8] = q[i].data[8*b +: 8];
        e_sbe = e_sbe | q[i].be;
      end
    end
  endtask

  task automatic model_update(input ent_t qi[$], input bit mrg, output ent_t qo[$]);
    logic d;
    int tgt;
    logic [DW-1:0] sd;
    logic [BW-1:0] sb;
    ent_t e;
    bit pop;
    qo = qi;
    model_eval(qi, mrg, d, tgt, sd, sb);
    pop = (qi.size() > 0) && memdone;
    if (d && byteen != '0) begin
      if (tgt >= 0) begin
        e = qo[tgt];
        for (int b = 0; b < BW; b++) if (byteen[b]) e.data[8*b +: 8] = data[8*b +: 8];
        e.be = e.be | byteen;
        qo[tgt] = e;
      end else begin
        e.adr = adr; e.data = data; e.be = byteen;
        qo.push_back(e);
      end
    end
    if (pop) void'(qo.pop_front());
  endtask

  task automatic check_inst(input string tag, input ent_t q[$], input bit mrg,
                            input logic a_done, input logic [CW-1:0] a_count, input logic a_memen,
                            input logic [AW-1:0] a_madr, input logic [DW-1:0] a_mdata,
                            input logic [BW-1:0] a_mbe, input logic a_hit,
                            input logic [DW-1:0] a_sdata, input logic [BW-1:0] a_sbe,
                            input logic a_empty);
    logic e_done;
    int tgt;
    logic [DW-1:0] e_sdata;
    logic [BW-1:0] e_sbe;
    ent_t h;
    model_eval(q, mrg, e_done, tgt, e_sdata, e_sbe);
    h.adr = '0; h.data = '0; h.be = '0;
    if (q.size() > 0) h = q[0];
    check({tag, ".done"},    64'(a_done),   64'(e_done));
    check({tag, ".count"},   64'(a_count),  64'(q.size()));
    check({tag, ".memen"},   64'(a_memen),  64'(q.size() > 0));
    check({tag, ".memadr"},  64'(a_madr),   64'(h.adr));
    check({tag, ".memdata"}, 64'(a_mdata),  64'(h.data));
    check({tag, ".membe"},   64'(a_mbe),    64'(h.be));
    check({tag, ".hit"},     64'(a_hit),    64'(e_sbe != '0));
    check({tag, ".sdata"},   64'(a_sdata),  64'(e_sdata));
    check({tag, ".sbe"},     64'(a_sbe),    64'(e_sbe));
    check({tag, ".empty"},   64'(a_empty),  64'(q.size() == 0));
  endtask

  logic [AW-1:0] fx_adr  [3] = '{30'd10, 30'd20, 30'd20};
  logic [DW-1:0] fx_data [3] = '{32'hAAAAAAAA, 32'h000000AA, 32'hBB000000};
  logic [BW-1:0] fx_be   [3] = '{4'hF, 4'h1, 4'h8};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    string s;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    //   rst en fl md  adr data          be    sadr  done cnt men madr mdata        mbe  hit sdata        sbe
    add(0, 1, 0, 0,  0, 32'hDEADBEEF, 4'hF, 0,    0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  0, 32'hDEADBEEF, 4'hF, 0,    1, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 0, 0, 1,  0, 32'h0,        4'h0, 0,    0, 1, 1, 0, 32'hDEADBEEF, 4'hF, 1, 32'hDEADBEEF, 4'hF);
    add(1, 1, 0, 0,  0, 32'h10,       4'hF, 3,    1, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  1, 32'h11,       4'hF, 3,    1, 1, 1, 0, 32'h10,       4'hF, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  2, 32'h12,       4'hF, 3,    1, 2, 1, 0, 32'h10,       4'hF, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  3, 32'h13,       4'hF, 3,    1, 3, 1, 0, 32'h10,       4'hF, 0, 32'h0,        4'h0);
    add(1, 1, 0, 1,  4, 32'h14,       4'hF, 3,    0, 4, 1, 0, 32'h10,       4'hF, 1, 32'h13,       4'hF);
    add(1, 1, 0, 0,  4, 32'h14,       4'hF, 3,    1, 3, 1, 1, 32'h11,       4'hF, 1, 32'h13,       4'hF);
    add(1, 0, 0, 0,  0, 32'h0,        4'h0, 4,    0, 4, 1, 1, 32'h11,       4'hF, 1, 32'h14,       4'hF);
    add(0, 0, 0, 0,  0, 32'h0,        4'h0, 4,    0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0, 10, 32'hAAAAAAAA, 4'hF, 20,   1, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0, 20, 32'h000000AA, 4'h1, 20,   1, 1, 1, 10, 32'hAAAAAAAA, 4'hF, 0, 32'h0,       4'h0);
    add(1, 1, 0, 0, 20, 32'hBB000000, 4'h8, 20,   1, 2, 1, 10, 32'hAAAAAAAA, 4'hF, 1, 32'h000000AA, 4'h1);
    add(1, 0, 0, 0,  0, 32'h0,        4'h0, 20,   0, 2, 1, 10, 32'hAAAAAAAA, 4'hF, 1, 32'hBB0000AA, 4'h9);
    add(0, 0, 0, 0,  0, 32'h0,        4'h0, 20,   0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  0, 32'hAAAAAAAA, 4'hF, 0,    1, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  0, 32'h000000BB, 4'h1, 0,    1, 1, 1, 0, 32'hAAAAAAAA, 4'hF, 1, 32'hAAAAAAAA, 4'hF);
    add(1, 0, 0, 1,  0, 32'h0,        4'h0, 0,    0, 2, 1, 0, 32'hAAAAAAAA, 4'hF, 1, 32'hAAAAAABB, 4'hF);
    add(1, 0, 0, 1,  0, 32'h0,        4'h0, 0,    0, 1, 1, 0, 32'h000000BB, 4'h1, 1, 32'h000000BB, 4'h1);
    add(1, 0, 0, 0,  0, 32'h0,        4'h0, 0,    0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  5, 32'h55,       4'hF, 0,    1, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  6, 32'h66,       4'hF, 0,    1, 1, 1, 5, 32'h55,       4'hF, 0, 32'h0,        4'h0);
    add(1, 1, 1, 1,  7, 32'h77,       4'hF, 0,    0, 2, 1, 5, 32'h55,       4'hF, 0, 32'h0,        4'h0);
    add(1, 1, 1, 1,  7, 32'h77,       4'hF, 0,    0, 1, 1, 6, 32'h66,       4'hF, 0, 32'h0,        4'h0);
    add(1, 1, 1, 0,  7, 32'h77,       4'hF, 0,    0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 1, 0, 0,  0, 32'h0,        4'h0, 0,    1, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);
    add(1, 0, 0, 0,  0, 32'h0,        4'h0, 0,    0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0);

    @(negedge clk);
    foreach (vq[i]) begin
      v = vq[i];
      drive(v.rst, v.en, v.fl, v.md, int'(v.adr), v.data, v.be, int'(v.sadr));
      #2;
      s = $sformatf("row%0d", i);
      check({s, ".done"},    64'(m_done),  64'(v.done));
      check({s, ".count"},   64'(m_count), 64'(v.cnt));
      check({s, ".memen"},   64'(m_memen), 64'(v.memen));
      check({s, ".memadr"},  64'(m_madr),  64'(v.madr));
      check({s, ".memdata"}, 64'(m_mdata), 64'(v.mdata));
      check({s, ".membe"},   64'(m_mbe),   64'(v.mbe));
      check({s, ".hit"},     64'(m_hit),   64'(v.hit));
      check({s, ".sdata"},   64'(m_sdata), 64'(v.sdata));
      check({s, ".sbe"},     64'(m_sbe),   64'(v.sbe));
      check({s, ".empty"},   64'(m_empty), 64'(v.cnt == 0));
      $display("vec %0d: rst=%b en=%b flush=%b memdone=%b adr=%0d be=%h -> done=%b count=%0d memadr=%0d",
               i, v.rst, v.en, v.fl, v.md, v.adr, v.be, m_done, m_count, m_madr);
      tick();
    end

    // ---------------- MERGE=0 keeps both adr-20 writes, in issue order ----------------
    drive(0, 0, 0, 0, 0, 0, 0, 20);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, int'(fx_adr[k]), fx_data[k], fx_be[k], 20);
      #2;
      check($sformatf("fifo.wr%0d.done", k), 64'(f_done), 64'd1);
      $display("fifo write %0d: adr=%0d data=%h be=%h done=%b", k, fx_adr[k], fx_data[k], fx_be[k], f_done);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 20);
    #2;
    check("fifo.count3",  64'(f_count), 64'd3);
    check("merge.count2", 64'(m_count), 64'd2);
    check("fifo.sdata",   64'(f_sdata), 64'h00000000BB0000AA);
    check("fifo.sbe",     64'(f_sbe),   64'h9);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 0, 0, 0, 20);
      #2;
      check($sformatf("fifo.drain%0d.memen", k), 64'(f_memen), 64'd1);
      check($sformatf("fifo.drain%0d.adr", k),   64'(f_madr),  64'(fx_adr[k]));
      check($sformatf("fifo.drain%0d.data", k),  64'(f_mdata), 64'(fx_data[k]));
      check($sformatf("fifo.drain%0d.be", k),    64'(f_mbe),   64'(fx_be[k]));
      $display("fifo drain %0d: adr=%0d data=%h be=%h", k, f_madr, f_mdata, f_mbe);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 20);
    #2;
    check("fifo.drained.count", 64'(f_count), 64'd0);
    check("fifo.drained.empty", 64'(f_empty), 64'd1);
    tick();

    // ---------------- random run against the model ----------------
    for (int c = 0; c < 400; c++) begin
      reset    = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      en       = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 9) == 0);
      memdone  = ($urandom_range(0, 1) == 1);
      adr      = AW'($urandom_range(0, 5));
      snoopadr = AW'($urandom_range(0, 5));
      data     = $urandom;
      byteen   = ($urandom_range(0, 7) == 0) ? 4'h0 : BW'($urandom_range(1, 15));
      if (!reset) begin
        qm.delete();
        qf.delete();
      end
      #2;
      check_inst($sformatf("rnd%0d.m", c), qm, 1'b1, m_done, m_count, m_memen, m_madr, m_mdata,
                 m_mbe, m_hit, m_sdata, m_sbe, m_empty);
      check_inst($sformatf("rnd%0d.f", c), qf, 1'b0, f_done, f_count, f_memen, f_madr, f_mdata,
                 f_mbe, f_hit, f_sdata, f_sbe, f_empty);
      $display("rnd %0d: rst=%b en=%b flush=%b adr=%0d be=%h memdone=%b -> m.done=%b m.count=%0d f.done=%b f.count=%0d",
               c, reset, en, flush, adr, byteen, memdone, m_done, m_count, f_done, f_count);
      if (reset) begin
        model_update(qm, 1'b1, qm);
        model_update(qf, 1'b0, qf);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
